// File: rtl/reg_move_ctrl_if.sv
// Command/response handshake bundle between a requester and reg_move_ctrl.
// master = requester side, slave = sequencer side.
interface reg_move_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_src;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/reg_move_ctrl.sv
// WRITE / READ / MOVE command sequencer in front of a 32x8 register memory.
// Optional MOVE read-back verify is enabled by defining MOVE_VERIFY_EN.
module reg_move_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_move_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR, RD, MRD, MWR,
`ifdef MOVE_VERIFY_EN
        MVF,
`endif
        RSP
    } state_t;

    // Per-command context: destination and the value being written/moved.
    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] val;
    } ctx_t;

    state_t            state_q, state_d;
    ctx_t              ctx_q, ctx_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_d, re_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef MOVE_VERIFY_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ctx_q        <= '0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
`ifdef MOVE_VERIFY_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ctx_q        <= ctx_d;
            mem_address  <= addr_d;
            mem_data_in  <= wdata_d;
            mem_write_en <= we_d;
            mem_read_en  <= re_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
`ifdef MOVE_VERIFY_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // Next-state logic also computes the next value of every registered
    // memory-side output, so the enables are asserted in the state cycle itself.
    always_comb begin
        state_d     = state_q;
        ctx_d       = ctx_q;
        addr_d      = mem_address;
        wdata_d     = mem_data_in;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef MOVE_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ctx_d.dst = bus.cmd_addr;
                    case (bus.cmd_op)
                        OP_NOP: begin
                            state_d     = RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
`ifdef MOVE_VERIFY_EN
                            rsp_err_d   = 1'b0;
`endif
                        end
                        OP_WRITE: begin
                            state_d   = WR;
                            ctx_d.val = bus.cmd_data;
                            we_d      = 1'b1;
                            addr_d    = bus.cmd_addr;
                            wdata_d   = bus.cmd_data;
                        end
                        OP_READ: begin
                            state_d = RD;
                            re_d    = 1'b1;
                            addr_d  = bus.cmd_addr;
                        end
                        OP_MOVE: begin
                            state_d = MRD;
                            re_d    = 1'b1;
                            addr_d  = bus.cmd_src;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ctx_q.val;
`ifdef MOVE_VERIFY_EN
                rsp_err_d   = 1'b0;
`endif
            end
            RD: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_data_out;
`ifdef MOVE_VERIFY_EN
                rsp_err_d   = 1'b0;
`endif
            end
            MRD: begin
                state_d   = MWR;
                ctx_d.val = mem_data_out;
                we_d      = 1'b1;
                addr_d    = ctx_q.dst;
                wdata_d   = mem_data_out;
            end
            MWR: begin
`ifdef MOVE_VERIFY_EN
                state_d     = MVF;
                re_d        = 1'b1;
                addr_d      = ctx_q.dst;
`else
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ctx_q.val;
`endif
            end
`ifdef MOVE_VERIFY_EN
            MVF: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ctx_q.val;
                rsp_err_d   = (mem_data_out != ctx_q.val);
            end
`endif
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef MOVE_VERIFY_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    a_enables_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(mem_write_en && mem_read_en));
    a_rsp_one_cycle: assert property (
        @(posedge clk) disable iff (!rst_n) rsp_valid_q |=> !rsp_valid_q);

endmodule

// File: tb/tb_reg_move_ctrl.sv
// Bench for reg_move_ctrl: register-memory model, command-level scoreboard
// and directed scenarios with literal expectations.
module tb_reg_move_ctrl;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam logic [1:0] NOP = 2'b00, WRITE = 2'b01, READ = 2'b10, MOVE = 2'b11;
`ifdef MOVE_VERIFY_EN
    localparam int LAT_MV = 4;
`else
    localparam int LAT_MV = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_write_en, mem_read_en;
    logic [DW-1:0] mem_data_in, mem_data_out;

    reg_move_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    reg_move_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // RegisterMemory stand-in; 'corrupt' flips bit 0 of written data.
    logic [DW-1:0] mem [32];
    logic          mem_init = 1'b1;
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7);
        end else if (mem_write_en) begin
            mem[mem_address] <= mem_data_in ^ {7'd0, corrupt};
        end
    end
    assign mem_data_out = mem_read_en ? mem[mem_address] : '0;

    // Command-level scoreboard: each accepted command is due a response
    // (latency-1) cycles after its accept edge; effects land at that point.
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] a, s;
        logic [DW-1:0] d;
        logic          cor;
        int            due;
    } cmd_t;
    cmd_t q[$];
    logic [DW-1:0] model_regs [32];
    int cyc = 0;
    int last_acc_cyc = 0, n_acc = 0;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            NOP:     return 1;
            WRITE:   return 2;
            READ:    return 2;
            default: return LAT_MV;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
            cmd_t c;
            c.op = bus.cmd_op; c.a = bus.cmd_addr; c.s = bus.cmd_src;
            c.d = bus.cmd_data; c.cor = corrupt;
            c.due = cyc + lat_of(bus.cmd_op) - 1;
            q.push_back(c);
            last_acc_cyc = cyc;
            n_acc++;
        end
    end

    int            n_rsp = 0, n_wr = 0, n_rd = 0, rsp_cyc = 0;
    logic [DW-1:0] last_rsp, wr_data, ev;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          last_err, ee, exp_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            if (mem_init) for (int i = 0; i < 32; i++) model_regs[i] = 8'(i * 7);
        end else begin
            chk("cmd_ready", bus.cmd_ready, q.size() == 0);
            chk("enables_exclusive", mem_write_en & mem_read_en, 0);
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("rsp_valid", bus.rsp_valid, exp_v);
            if (exp_v) begin
                ee = 1'b0;
                case (q[0].op)
                    NOP:   ev = '0;
                    WRITE: begin ev = q[0].d; model_regs[q[0].a] = q[0].d; end
                    READ:  ev = model_regs[q[0].a];
                    default: begin
                        ev = model_regs[q[0].s];
                        model_regs[q[0].a] = ev ^ {7'd0, q[0].cor};
`ifdef MOVE_VERIFY_EN
                        ee = q[0].cor;
`endif
                    end
                endcase
                chk("rsp_data", bus.rsp_data, ev);
                chk("rsp_err", bus.rsp_err, ee);
                void'(q.pop_front());
            end
            if (bus.rsp_valid) begin
                n_rsp++; rsp_cyc = cyc; last_rsp = bus.rsp_data; last_err = bus.rsp_err;
            end
            if (mem_write_en) begin n_wr++; wr_addr = mem_address; wr_data = mem_data_in; end
            if (mem_read_en) begin n_rd++; rd_addr = mem_address; end
        end
    end

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, s,
                        input logic [DW-1:0] d, input bit hold);
        int g;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_addr = a; bus.cmd_src = s; bus.cmd_data = d;
        g = 0;
        while (!bus.cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((q.size() != 0 || !bus.cmd_ready) && g < 100);
        if (g >= 100) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    int n0, r0, a0;

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = NOP;
        bus.cmd_addr = '0; bus.cmd_src = '0; bus.cmd_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_write_en", mem_write_en, 0);
        chk("rst_read_en", mem_read_en, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_data_in", mem_data_in, 0);
        @(negedge clk);
        mem_init = 1'b0;
        rst_n = 1'b1;

        // WRITE 15 <- 0x0F
        n0 = n_wr;
        send(WRITE, 15, 0, 8'h0F, 0);
        wait_idle();
        chk("wr_latency", rsp_cyc - last_acc_cyc + 1, 2);
        chk("wr_rsp_data", last_rsp, 8'h0F);
        chk("wr_count", n_wr - n0, 1);
        chk("wr_addr", wr_addr, 15);
        chk("wr_data", wr_data, 8'h0F);

        // READ 15
        n0 = n_rd;
        send(READ, 15, 0, 8'h00, 0);
        wait_idle();
        chk("rd_latency", rsp_cyc - last_acc_cyc + 1, 2);
        chk("rd_rsp_data", last_rsp, 8'h0F);
        chk("rd_count", n_rd - n0, 1);
        chk("rd_addr", rd_addr, 15);

        // MOVE 15 -> 22, then READ 22
        send(MOVE, 22, 15, 8'hEE, 0);
        wait_idle();
        chk("mv_latency", rsp_cyc - last_acc_cyc + 1, LAT_MV);
        chk("mv_rsp_data", last_rsp, 8'h0F);
        chk("mv_wr_addr", wr_addr, 22);
        chk("mv_wr_data", wr_data, 8'h0F);
        send(READ, 22, 0, 8'h00, 0);
        wait_idle();
        chk("rd22_after_mv", last_rsp, 8'h0F);

        // NOP, MOVE src==dst, address extremes
        n0 = n_wr;
        send(NOP, 3, 4, 8'h55, 0);
        wait_idle();
        chk("nop_latency", rsp_cyc - last_acc_cyc + 1, 1);
        chk("nop_rsp_data", last_rsp, 8'h00);
        chk("nop_no_write", n_wr - n0, 0);
        send(MOVE, 7, 7, 8'h00, 0);
        wait_idle();
        chk("mv_same_data", last_rsp, 8'd49);
        send(WRITE, 0, 0, 8'hA5, 0);
        send(WRITE, 31, 0, 8'hFF, 0);
        send(MOVE, 0, 31, 8'h00, 0);
        send(READ, 0, 0, 8'h00, 0);
        wait_idle();
        chk("rd0_after_mv", last_rsp, 8'hFF);

        // Reset during MRD of MOVE 15 -> 22
        send(WRITE, 15, 0, 8'h33, 0);
        wait_idle();
        r0 = n_rsp;
        send(MOVE, 22, 15, 8'h00, 0);
        chk("mrd_read_en", mem_read_en, 1);
        chk("mrd_address", mem_address, 15);
        rst_n = 1'b0;
        #1;
        chk("abort_read_en", mem_read_en, 0);
        chk("abort_write_en", mem_write_en, 0);
        chk("abort_address", mem_address, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_rsp", n_rsp - r0, 0);
        send(READ, 22, 0, 8'h00, 0);
        wait_idle();
        chk("rd22_after_abort", last_rsp, 8'h0F);

        // cmd_valid held across three back-to-back commands
        r0 = n_rsp; a0 = n_acc;
        send(WRITE, 3, 0, 8'h11, 1);
        send(READ, 3, 0, 8'h00, 1);
        send(MOVE, 9, 3, 8'h00, 1);
        bus.cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("held_rsp_count", n_rsp - r0, 3);
        chk("held_acc_count", n_acc - a0, 3);
        chk("held_last_rsp", last_rsp, 8'h11);

`ifdef MOVE_VERIFY_EN
        corrupt = 1'b1;
        send(MOVE, 10, 9, 8'h00, 0);
        wait_idle();
        corrupt = 1'b0;
        chk("verify_err", last_err, 1);
        chk("verify_data", last_rsp, 8'h11);
`endif

        for (int i = 0; i < 32; i++) chk($sformatf("mem_%0d", i), mem[i], model_regs[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
